srl_sra_seq: RTL and testbench
==============================

SRL_SRA_SEQ -- requirements
Module: srl_sra_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a new right shift; sampled only in IDLE.
REQ-005 flush  input  1  pipeline kill; aborts any in-flight shift.
REQ-006 arith  input  1  0 = logical right shift (SRL), 1 = arithmetic right shift (SRA).
REQ-007 data_in  input  32  operand; captured only on the accept edge.
REQ-008 shamt  input  5  shift amount 0..31; captured only on the accept edge.
REQ-009 busy  output  1  high in SHIFT and DONE.
REQ-010 done  output  1  single-cycle pulse; result is valid while done is high.
REQ-011 result  output  32  shifted value; holds until the next accept.

Function
REQ-012 The FSM SHALL have three states:
  - IDLE: waiting for start.
  - SHIFT: iterating right shifts.
  - DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
REQ-013 Accept SHALL occur on a rising edge where state=IDLE, start=1 and flush=0.
REQ-014 On accept the block SHALL load result<=data_in, cnt<=shamt and sign<=data_in[31] if arith else 0.
  - next state = DONE if shamt=0, else SHIFT.
REQ-015 Each SHIFT edge SHALL shift result right by one step, filling vacated MSBs with sign, and decrement cnt by the step size.
  - next state = DONE when cnt reaches 0.
REQ-016 Step size SHALL be 1 when FAST_SHIFT4_EN is undefined.
REQ-017 Latency (base build): with accept at edge N, done SHALL be high for the cycle after edge N+shamt.
  - shamt=0 gives done in the cycle after edge N.
REQ-018 start asserted while busy=1 SHALL be ignored.
  - No queuing.
  - The captured operands SHALL be unaffected.
REQ-019 flush=1 on any edge SHALL force state to IDLE with no done pulse.
  - flush SHALL win over a simultaneous start.
  - A flush in DONE SHALL also suppress done on the following cycle.
  - result keeps its partial value and is not valid.
REQ-020 Arithmetic SHALL be exactly 32 bits with no wrap.
  - SRA of a negative value SHALL saturate to 32'hFFFFFFFF for shamt=31 applied to 32'h80000000.
  - SRL SHALL fill with 0.
REQ-021 busy and done SHALL be decoded from registered state only (no combinational path from inputs).

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for clk, force:
  - state=IDLE
  - busy=0
  - done=0
  - result=32'h0
  - cnt=0
  - sign=0
REQ-023 Reset asserted mid-shift SHALL abort the operation with no done pulse.
  - The first accept after rst_n deasserts SHALL behave as from power-up.

Configuration
REQ-024 Macro FAST_SHIFT4_EN, when defined, SHALL make the SHIFT step 4 bits while cnt>=4 and 1 bit otherwise.
  - Latency becomes floor(shamt/4)+(shamt mod 4) SHIFT cycles; shamt=0 is unchanged.
  - Results SHALL be bit-identical to the base build.
REQ-025 When FAST_SHIFT4_EN is undefined, only 1-bit steps SHALL exist and the 4-bit datapath SHALL not be synthesized.

Verification
REQ-026 SRL basic: data_in=32'hF000000F, shamt=4, arith=0.
  - Required: result=32'h0F000000.
  - Base build: done in the cycle after edge N+4.
  - FAST build: done in the cycle after edge N+1.
REQ-027 SRA sign fill: data_in=32'h80000000, shamt=31, arith=1.
  - Required: result=32'hFFFFFFFF.
  - Base build: done after 31 SHIFT edges.
  - FAST build: done after 10 SHIFT edges.
REQ-028 Zero shift: data_in=32'h12345678, shamt=0.
  - Required: done the cycle after accept, result=32'h12345678, busy high for exactly one cycle.
REQ-029 Busy-ignore and flush:
  - Step 1: start with shamt=8.
  - Step 2: pulse start with different data at cycle 3; it SHALL be ignored, and the original result SHALL appear.
  - Step 3: restart with shamt=8, assert flush at cycle 5.
  - Step 4: required: no done, state IDLE the next cycle, and a fresh start is accepted the cycle after that.
REQ-030 Async reset: drop rst_n mid-shift, between clock edges.
  - Required: busy=0 and result=0 before the next clk edge.
  - No done pulse appears after release.

Source files
------------

// File: rtl/srl_sra_seq.sv
// Iterative SRL/SRA shifter: IDLE -> SHIFT -> DONE, with flush and async reset.
// Define FAST_SHIFT4_EN to take 4-bit steps while at least 4 bits remain.
module srl_sra_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic        arith,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_result;
  logic [4:0]  r_cnt;
  logic        r_sign;
  logic        w_accept;
  logic [31:0] w_shifted;
  logic [4:0]  w_cnt_next;

  assign w_accept = (r_state == S_IDLE) && start && !flush;

`ifdef FAST_SHIFT4_EN
  always_comb begin
    w_shifted  = {r_sign, r_result[31:1]};
    w_cnt_next = r_cnt - 5'd1;
    if (r_cnt >= 5'd4) begin
      w_shifted  = {{4{r_sign}}, r_result[31:4]};
      w_cnt_next = r_cnt - 5'd4;
    end
  end
`else
  assign w_shifted  = {r_sign, r_result[31:1]};
  assign w_cnt_next = r_cnt - 5'd1;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (shamt == 5'd0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (w_cnt_next == 5'd0)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // flush beats everything, including a same-edge start
    if (flush)
      w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 32'h0;
      r_cnt    <= 5'd0;
      r_sign   <= 1'b0;
    end else if (w_accept) begin
      r_result <= data_in;
      r_cnt    <= shamt;
      r_sign   <= arith & data_in[31];
    end else if (r_state == S_SHIFT && !flush) begin
      r_result <= w_shifted;
      r_cnt    <= w_cnt_next;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_srl_sra_seq.sv
// Directed scoreboard bench for srl_sra_seq.
// Expected results/latencies queued at accept, popped at done.
module tb_srl_sra_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        arith = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [4:0]  shamt = 5'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] q_res[$];
  int          q_lat[$];

  always #5 clk = ~clk;

  srl_sra_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .arith   (arith),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  function automatic logic [31:0] model(input logic [31:0] d,
                                        input logic [4:0] s,
                                        input logic a);
    if (a) return 32'($signed(d) >>> s);
    return d >> s;
  endfunction

  function automatic int lat(input logic [4:0] s);
`ifdef FAST_SHIFT4_EN
    return int'(s) / 4 + int'(s) % 4;
`else
    return int'(s);
`endif
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept_op(input logic [31:0] d,
                           input logic [4:0] s,
                           input logic a,
                           input bit push);
    @(negedge clk);
    start = 1'b1;
    data_in = d;
    shamt = s;
    arith = a;
    @(posedge clk);
    if (push) begin
      q_res.push_back(model(d, s, a));
      q_lat.push_back(lat(s));
    end
    @(negedge clk);
    start = 1'b0;
    data_in = $urandom;
    shamt = 5'($urandom);
    arith = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, input int elapsed);
    int k;
    logic [31:0] er;
    int el;
    k = elapsed;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    er = q_res.pop_front();
    el = q_lat.pop_front();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(k), 32'(el));
    check({tag, "_res"}, result, er);
    @(negedge clk);
    check({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    logic [31:0] held;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    accept_op(32'hF000000F, 5'd4, 1'b0, 1'b1);
    wait_done("srl_basic", 0);
    check("srl_const", result, 32'h0F000000);

    accept_op(32'h80000000, 5'd31, 1'b1, 1'b1);
    wait_done("sra_fill", 0);
    check("sra_const", result, 32'hFFFFFFFF);

    accept_op(32'h12345678, 5'd0, 1'b0, 1'b1);
    wait_done("zero", 0);

    accept_op(32'h80000000, 5'd31, 1'b0, 1'b1);
    wait_done("srl_max", 0);

    accept_op(32'h7FFF0000, 5'd7, 1'b1, 1'b1);
    wait_done("sra_pos", 0);

    accept_op(32'hA5A5A5A5, 5'd8, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    data_in = 32'h13572468;
    shamt = 5'd3;
    arith = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ign", 3);

    accept_op(32'hCAFEBABE, 5'd8, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_part", result, 32'h0CAFEBAB);
    @(negedge clk);
    check("flush_idle", {30'b0, busy, done}, 32'd0);
    accept_op(32'h0000F00D, 5'd2, 1'b1, 1'b1);
    wait_done("post_flush", 0);

    held = result;
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    data_in = 32'hDEADBEEF;
    shamt = 5'd1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_win", 32'(busy), 32'd0);
    check("flush_win_res", result, held);

    accept_op(32'h90000001, 5'd20, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_res", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("arst_nodone", 32'(ndone), 32'd0);
    accept_op(32'h800000F0, 5'd5, 1'b1, 1'b1);
    wait_done("post_rst", 0);

    for (int i = 0; i < 6; i++) begin
      accept_op($urandom, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'b1);
      wait_done("rand", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
